reg_file_wb_scheduler: RTL
==========================

REG_FILE_WB_SCHEDULER -- requirements
Module: reg_file_wb_scheduler

Interface
REQ-001 SHALL have parameter NREGS, default 32, number of architectural registers (power of two, >=4).
REQ-002 SHALL have parameter AW, default $clog2(NREGS), register address width.
REQ-003 SHALL have parameter DW, default 32, write data width.
REQ-004 SHALL have parameter LQ_DEPTH, default 4, outstanding-load queue depth (power of two, >=2).
REQ-005 SHALL have parameter LINK_REG, default NREGS-1, link destination for non-register jumps.
REQ-006 clock  input  1  single clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 w_issue_valid  input  1  decoded instruction presented.
REQ-009 w_issue_ready  output  1  instruction accepted when valid & ready.
REQ-010 w_alu_op, w_imm_op, w_jump_op, w_reg_jump_op, w_mem_op, w_write_op  input  1 each  decode class flags.
REQ-011 w_rs, w_rt, w_rd  input  AW each  source/destination fields.
REQ-012 w_alu_result  input  DW  ALU or link value for non-load writers.
REQ-013 w_mem_rvalid  input  1  load data return strobe; w_mem_rdata  input  DW.
REQ-014 w_en_out  output  1  register file write enable; w_waddr_out  output  AW; w_wdata_out  output  DW.
REQ-015 w_busy_mask  output  NREGS  scoreboard pending-write bits.
REQ-016 w_lq_count  output  $clog2(LQ_DEPTH)+1  loads outstanding; w_lq_err  output  1  sticky underflow flag.

Function
REQ-017 Destination SHALL be: load (mem & ~write) -> rt; alu & imm -> rt; jump & reg_jump -> rd; jump & ~reg_jump -> LINK_REG; alu -> rd; store or no class -> none; priority in that order.
REQ-018 An instruction SHALL write only if it has a destination and destination != 0.
REQ-019 Stall (ready=0) SHALL occur when: rs or rt busy; destination busy (WAW); load with LQ full; or non-load writer while w_mem_rvalid=1 (port conflict, load wins).
REQ-020 Accepted non-load writer SHALL drive w_en_out=1, w_waddr_out=dest, w_wdata_out=w_alu_result on the next cycle (1-cycle latency).
REQ-021 Accepted load SHALL push dest into LQ and, if dest!=0, set busy[dest] the next cycle.
REQ-022 w_mem_rvalid with LQ non-empty SHALL pop head; next cycle w_en_out=(head!=0), w_waddr_out=head, w_wdata_out=w_mem_rdata; busy[head] cleared same edge.
REQ-023 Loads SHALL complete in issue order; push and pop in the same cycle SHALL leave count unchanged, legal even when full.
REQ-024 w_mem_rvalid with LQ empty SHALL be ignored for writes and set w_lq_err until reset.
REQ-025 busy[0] SHALL never be set; pointers SHALL wrap modulo LQ_DEPTH.
REQ-026 w_en_out SHALL be 0 in any cycle with no scheduled write; waddr/wdata hold last value.
REQ-027 Stores and non-writers SHALL be accepted subject only to REQ-019 source checks and produce no write.

Reset
REQ-028 On reset assertion, immediately: w_en_out=0, w_waddr_out=0, w_wdata_out=0, busy mask=0, LQ empty, count=0, w_lq_err=0.
REQ-029 Reset mid-operation SHALL discard outstanding loads; later returns count as underflow.
REQ-030 w_issue_ready SHALL be 1 during and after reset while no stall condition holds.

Configuration
REQ-031 Macro WB_SCOREBOARD_EN: defined -> busy tracking and rs/rt/WAW stalls per REQ-019; undefined -> w_busy_mask tied 0, stalls only on LQ full and port conflict.

Verification
REQ-032 ALU rd=5, result 0xDEAD -> next cycle en=1, waddr=5, wdata=0xDEAD.
REQ-033 JAL (jump, ~reg_jump) -> waddr=31; JALR rd=0 -> no write (en=0).
REQ-034 Load rt=7, then ALU rs=7 -> ready=0 until rvalid rdata=0x1234; write addr 7 data 0x1234, busy[7]=0, ALU then accepted.
REQ-035 Four loads rt=1..4 without returns -> count=4, fifth load stalled; four returns write 1,2,3,4 in order.
REQ-036 rvalid with count=0 -> en=0, lq_err=1 and stays 1; reset clears it.
REQ-037 ALU issue with rvalid=1 same cycle -> ready=0, load write first, ALU written one cycle later.

Source files
------------

// File: rtl/reg_file_wb_scheduler.sv
// reg_file_wb_scheduler
//   Register-file write-back scheduler. Works out each decoded instruction's
//   destination and arbitrates the single register-file write port between
//   1-cycle writers (ALU/immediate/link) and returning loads. Returning loads
//   are held in an in-order outstanding-load queue (LQ).
//
//   Optional feature: define WB_SCOREBOARD_EN to enable busy-register tracking.
//   When enabled, the block stalls on rs/rt read-after-write hazards and on
//   write-after-write hazards against pending loads. When undefined,
//   w_busy_mask is tied to zero and only LQ-full and port-conflict stalls apply.
//
// Ports
//   clock, reset          : clock; asynchronous active-high reset
//   w_issue_valid/ready   : issue handshake (accepted when valid & ready)
//   w_*_op                : decode class flags (alu, imm, jump, reg_jump, mem, write)
//   w_rs, w_rt, w_rd      : register fields
//   w_alu_result          : write data for non-load writers
//   w_mem_rvalid/rdata    : load data return
//   w_en_out/waddr/wdata  : register-file write port (registered)
//   w_busy_mask           : pending load destinations
//   w_lq_count, w_lq_err  : loads outstanding; sticky underflow flag
module reg_file_wb_scheduler #(
  parameter int NREGS    = 32,
  parameter int AW       = $clog2(NREGS),
  parameter int DW       = 32,
  parameter int LQ_DEPTH = 4,
  parameter int LINK_REG = NREGS - 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        w_issue_valid,
  output logic                        w_issue_ready,
  input  logic                        w_alu_op,
  input  logic                        w_imm_op,
  input  logic                        w_jump_op,
  input  logic                        w_reg_jump_op,
  input  logic                        w_mem_op,
  input  logic                        w_write_op,
  input  logic [AW-1:0]               w_rs,
  input  logic [AW-1:0]               w_rt,
  input  logic [AW-1:0]               w_rd,
  input  logic [DW-1:0]               w_alu_result,
  input  logic                        w_mem_rvalid,
  input  logic [DW-1:0]               w_mem_rdata,
  output logic                        w_en_out,
  output logic [AW-1:0]               w_waddr_out,
  output logic [DW-1:0]               w_wdata_out,
  output logic [NREGS-1:0]            w_busy_mask,
  output logic [$clog2(LQ_DEPTH):0]   w_lq_count,
  output logic                        w_lq_err
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [AW-1:0] LINK_ADDR = AW'(LINK_REG);
  localparam logic [CW-1:0] LQ_FULL   = CW'(LQ_DEPTH);

  logic [AW-1:0] lq_q [LQ_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          err_q;
  logic          en_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;

  logic          is_load, has_dest, writes;
  logic [AW-1:0] dest, head;
  logic          lq_empty, lq_full, pop, push, accept, alu_wr;
  logic          stall_sb, stall_lq, stall_port;

  // Destination priority: load, alu+imm, jalr, jal, alu.
  always_comb begin
    is_load  = w_mem_op & ~w_write_op;
    has_dest = 1'b1;
    dest     = w_rd;
    if (is_load)                        dest = w_rt;
    else if (w_alu_op && w_imm_op)      dest = w_rt;
    else if (w_jump_op && w_reg_jump_op) dest = w_rd;
    else if (w_jump_op)                 dest = LINK_ADDR;
    else if (w_alu_op)                  dest = w_rd;
    else begin
      has_dest = 1'b0;
      dest     = '0;
    end
  end

  assign writes   = has_dest & (dest != '0);
  assign lq_empty = (count_q == '0);
  assign lq_full  = (count_q == LQ_FULL);
  assign head     = lq_q[rd_ptr_q];
  assign pop      = w_mem_rvalid & ~lq_empty;

  // A load may enter a full queue when the head retires in the same cycle.
  assign stall_lq   = is_load & lq_full & ~pop;
  // Returning load data owns the write port; non-load writers wait.
  assign stall_port = writes & ~is_load & w_mem_rvalid;

`ifdef WB_SCOREBOARD_EN
  logic [NREGS-1:0] busy_q, busy_d;

  assign stall_sb = busy_q[w_rs] | busy_q[w_rt] | (writes & busy_q[dest]);

  // Clear-then-set is safe: a WAW stall prevents issuing to a busy register.
  always_comb begin
    busy_d = busy_q;
    if (pop)                     busy_d[head] = 1'b0;
    if (push && dest != '0)      busy_d[dest] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign w_busy_mask = busy_q;
`else
  logic unused_rs;
  assign unused_rs   = ^w_rs;
  assign stall_sb    = 1'b0;
  assign w_busy_mask = '0;
`endif

  assign w_issue_ready = ~(stall_sb | stall_lq | stall_port);
  assign accept        = w_issue_valid & w_issue_ready;
  assign push          = accept & is_load;
  assign alu_wr        = accept & writes & ~is_load;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Queue storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clock) begin
    if (push) lq_q[wr_ptr_q] <= dest;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      en_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (w_mem_rvalid && lq_empty) err_q <= 1'b1;
      if (pop) begin
        en_q    <= (head != '0);
        waddr_q <= head;
        wdata_q <= w_mem_rdata;
      end else if (alu_wr) begin
        en_q    <= 1'b1;
        waddr_q <= dest;
        wdata_q <= w_alu_result;
      end else begin
        en_q    <= 1'b0;
      end
    end
  end

  assign w_en_out    = en_q;
  assign w_waddr_out = waddr_q;
  assign w_wdata_out = wdata_q;
  assign w_lq_count  = count_q;
  assign w_lq_err    = err_q;

endmodule
